// File: rtl/mux_scan_seq.sv
// mux_scan_seq: loads a word, steps the 16:1 mux select 0..15, captures f per step.
// Optional `MUX_SCAN_CHECK_EN adds a sticky f != w[s] compare on err.
module mux_scan_seq #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] din,
    output logic        ready,
    output logic        busy,
    output logic [15:0] w,
    output logic [3:0]  s,
    input  logic        f,
    output logic [15:0] cap,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(STEP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       cap_edge;

    assign cap_edge = (cnt == LAST);
    assign ready    = (state == IDLE);
    assign busy     = (state == SCAN);

`ifndef MUX_SCAN_CHECK_EN
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            w     <= '0;
            s     <= '0;
            cap   <= '0;
            done  <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        w     <= din;
                        s     <= '0;
                        cap   <= '0;
                        cnt   <= '0;
                        state <= SCAN;
`ifdef MUX_SCAN_CHECK_EN
                        err   <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (cap_edge) begin
                        cap[s] <= f;
                        cnt    <= '0;
`ifdef MUX_SCAN_CHECK_EN
                        if (f != w[s]) err <= 1'b1;
`endif
                        // s stops at 15; DONE/IDLE keep it there
                        if (s == 4'd15) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq with a behavioral 16:1 mux in the loop.
// Two instances: STEP_CYCLES=1 and STEP_CYCLES=3.
module tb_mux_scan_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        force_zero = 1'b0;

    logic        start1 = 1'b0;
    logic [15:0] din1 = '0;
    logic        ready1, busy1, f1, done1, err1;
    logic [15:0] w1, cap1;
    logic [3:0]  s1;

    logic        start3 = 1'b0;
    logic [15:0] din3 = '0;
    logic        ready3, busy3, f3, done3, err3;
    logic [15:0] w3, cap3;
    logic [3:0]  s3;

    int errs = 0;
    int checks = 0;
    logic exp_err;

    always #5 clk = ~clk;

    assign f1 = force_zero ? 1'b0 : w1[s1];
    assign f3 = w3[s3];

    mux_scan_seq #(.STEP_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1),
        .ready(ready1), .busy(busy1), .w(w1), .s(s1), .f(f1),
        .cap(cap1), .done(done1), .err(err1)
    );

    mux_scan_seq #(.STEP_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .din(din3),
        .ready(ready3), .busy(busy3), .w(w3), .s(s3), .f(f3),
        .cap(cap3), .done(done3), .err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input string tag);
        int n;
        n = 0;
        while (done1 !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done1}, 32'd1);
    endtask

    initial begin
`ifdef MUX_SCAN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // async reset with no clock edge
        #3 rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, ready1}, 32'd1);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_w", {16'd0, w1}, 32'd0);
        chk("rst_s", {28'd0, s1}, 32'd0);
        chk("rst_cap", {16'd0, cap1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_err", {31'd0, err1}, 32'd0);
        chk("rst_ready3", {31'd0, ready3}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // basic scan, STEP_CYCLES=1
        start1 = 1'b1;
        din1 = 16'h0001;
        tick();
        start1 = 1'b0;
        chk("b_s0", {28'd0, s1}, 32'd0);
        chk("b_busy", {31'd0, busy1}, 32'd1);
        chk("b_w", {16'd0, w1}, 32'h0001);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("b_s%0d", i), {28'd0, s1}, 32'(i));
            chk("b_nodone", {31'd0, done1}, 32'd0);
        end
        tick();
        chk("b_done", {31'd0, done1}, 32'd1);
        chk("b_cap", {16'd0, cap1}, 32'h0001);
        chk("b_err", {31'd0, err1}, 32'd0);
        chk("b_ready_lo", {31'd0, ready1}, 32'd0);
        tick();
        chk("b_done_lo", {31'd0, done1}, 32'd0);
        chk("b_ready", {31'd0, ready1}, 32'd1);
        chk("b_s_hold", {28'd0, s1}, 32'd15);

        // pattern, STEP_CYCLES=3
        start3 = 1'b1;
        din3 = 16'hA5C3;
        tick();
        start3 = 1'b0;
        for (int k = 1; k < 48; k++) begin
            tick();
            chk($sformatf("p_s_k%0d", k), {28'd0, s3}, 32'(k / 3));
            chk("p_nodone", {31'd0, done3}, 32'd0);
        end
        tick();
        chk("p_done", {31'd0, done3}, 32'd1);
        chk("p_cap", {16'd0, cap3}, 32'hA5C3);
        chk("p_err", {31'd0, err3}, 32'd0);
        tick();
        chk("p_ready", {31'd0, ready3}, 32'd1);
        chk("p_done_lo", {31'd0, done3}, 32'd0);

        // start during SCAN is ignored
        start1 = 1'b1;
        din1 = 16'h1234;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        start1 = 1'b1;
        din1 = 16'hFFFF;
        tick();
        start1 = 1'b0;
        chk("h_w_kept", {16'd0, w1}, 32'h1234);
        wait_done1("h_done");
        chk("h_cap", {16'd0, cap1}, 32'h1234);
        tick();

        // start held high: back-to-back scans
        begin
            int t, t0, t1, nd;
            t = 0;
            nd = 0;
            t0 = 0;
            t1 = 0;
            start1 = 1'b1;
            din1 = 16'h00F0;
            while (nd < 2 && t < 80) begin
                tick();
                t++;
                if (done1) begin
                    if (nd == 0) t0 = t;
                    else t1 = t;
                    nd++;
                end
            end
            start1 = 1'b0;
            chk("bb_count", 32'(nd), 32'd2);
            chk("bb_gap", 32'(t1 - t0), 32'd18);
            chk("bb_cap", {16'd0, cap1}, 32'h00F0);
            t = 0;
            while (ready1 !== 1'b1 && t < 40) begin
                tick();
                t++;
            end
            chk("bb_idle", {31'd0, ready1}, 32'd1);
        end

        // fault injection: f stuck at 0
        force_zero = 1'b1;
        start1 = 1'b1;
        din1 = 16'hFFFF;
        tick();
        start1 = 1'b0;
        wait_done1("f_done");
        chk("f_cap", {16'd0, cap1}, 32'h0000);
        chk("f_err", {31'd0, err1}, {31'd0, exp_err});
        tick();
        chk("f_err_sticky", {31'd0, err1}, {31'd0, exp_err});
        force_zero = 1'b0;
        start1 = 1'b1;
        din1 = 16'h0003;
        tick();
        start1 = 1'b0;
        chk("f_err_clr", {31'd0, err1}, 32'd0);
        wait_done1("f2_done");
        chk("f2_cap", {16'd0, cap1}, 32'h0003);
        chk("f2_err", {31'd0, err1}, 32'd0);
        tick();

        // reset mid-scan at s=7
        start1 = 1'b1;
        din1 = 16'hFFFF;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        chk("r_s7", {28'd0, s1}, 32'd7);
        chk("r_partial", {16'd0, cap1}, 32'h007F);
        #2 rst = 1'b1;
        #1;
        chk("r_ready", {31'd0, ready1}, 32'd1);
        chk("r_busy", {31'd0, busy1}, 32'd0);
        chk("r_w", {16'd0, w1}, 32'd0);
        chk("r_s", {28'd0, s1}, 32'd0);
        chk("r_cap", {16'd0, cap1}, 32'd0);
        chk("r_done", {31'd0, done1}, 32'd0);
        chk("r_err", {31'd0, err1}, 32'd0);
        rst = 1'b0;
        start1 = 1'b1;
        din1 = 16'h8001;
        tick();
        start1 = 1'b0;
        chk("r2_busy", {31'd0, busy1}, 32'd1);
        chk("r2_s", {28'd0, s1}, 32'd0);
        chk("r2_cap", {16'd0, cap1}, 32'd0);
        wait_done1("r2_done");
        chk("r2_cap_end", {16'd0, cap1}, 32'h8001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Select-sequencer that drives the 16:1 multiplexer stage (`w[15:0]`, `s[3:0]` -> `f`).
- Accepts a 16-bit word through a start/ready handshake and holds it on `w`.
- Steps `s` through 0..15 and samples the mux output `f` back into a capture register.
- Signals completion with a one-cycle `done` pulse.
- Used as the upstream driver when the mux is operated as a parallel-to-serial stage and self-checked on silicon.

## Interface
- `STEP_CYCLES`, default 1: clock cycles each select value is held before `f` is sampled. Legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to load `din` and begin a scan.
- `din`  in  16  word to scan.
- `ready`  out  1  high only in IDLE; `start && ready` is a transfer.
- `busy`  out  1  high in SCAN.
- `w`  out  16  registered word driven to the mux data inputs.
- `s`  out  4  registered select driven to the mux.
- `f`  in  1  mux output, combinational from `w`/`s`.
- `cap`  out  16  captured bits; `cap[i]` is `f` sampled while `s == i`.
- `done`  out  1  one-cycle pulse after bit 15 is captured.
- `err`  out  1  sticky mismatch flag (see Configuration).

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- Reset values: `w=0`, `s=0`, `cap=0`, `done=0`, `err=0`, `busy=0`, `ready=1`. Step counter resets to 0.
- **IDLE:** on `start` high at a clock edge:
  - `w<=din`, `s<=0`, `cap<=0`, `err<=0`, step counter `<=0`.
  - Next state is SCAN.
  - `start` is ignored in SCAN and DONE. No queueing.
- **SCAN:** the step counter increments each cycle.
  - When the counter equals `STEP_CYCLES-1`, `cap[s]<=f` at that edge and the counter returns to 0.
  - If `s==15`, go to DONE; otherwise `s<=s+1`.
  - `s` never wraps during a scan.
- **DONE:** `done=1` for exactly this cycle, then IDLE.
- `w` and `s` hold their last values (`s=15`) in DONE and IDLE until the next transfer.
- `cap` holds until the next transfer.
- `f` is sampled only at capture edges. Glitches on `f` between captures have no effect.
- Asynchronous reset at any point (including mid-scan) forces all reset values immediately. A partial `cap` is discarded.

## Timing
- Transfer at edge E0. The first capture is at edge E0+`STEP_CYCLES`.
- Capture of bit i occurs at edge E0+(i+1)·`STEP_CYCLES`.
- `done` is high in the cycle after the bit-15 capture edge: from E0+16·`STEP_CYCLES` to E0+16·`STEP_CYCLES`+1.
- `ready` rises with IDLE re-entry at E0+16·`STEP_CYCLES`+1.
- Throughput: one word per 16·`STEP_CYCLES`+2 cycles with `start` held high.
- `w`/`s` are registered. The mux path `w,s -> f` has a full cycle (`STEP_CYCLES=1`) to settle before capture.
- All outputs are registered except `ready` and `busy`, which are decoded from state registers only.

## Configuration
- Macro: `MUX_SCAN_CHECK_EN`.
- **Defined:** at each capture edge, if `f != w[s]` then `err<=1`.
  - `err` is sticky until the next transfer or reset.
  - `done` still pulses on a failed scan.
- **Undefined:** the compare logic is absent and `err` is tied to 0. The port remains present so instantiations do not change.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge -> `ready=1`, `busy=0`, `w=0`, `s=0`, `cap=0`, `done=0`, `err=0` immediately.
- Basic scan, loop through the real mux, `STEP_CYCLES=1`, `din=16'h0001`:
  - `s` reads 0,1,…,15 on consecutive cycles.
  - `cap=16'h0001`, `done` pulses 16 cycles after the transfer edge, `err=0`.
- Pattern, `STEP_CYCLES=3`, `din=16'hA5C3`:
  - Each `s` value is held 3 cycles.
  - `cap=16'hA5C3` with `done` 48 cycles after the transfer edge.
  - `ready` returns one cycle later.
- Handshake:
  - Pulse `start` with `din=16'hFFFF` during SCAN of `16'h1234` -> ignored, `cap=16'h1234`.
  - Hold `start` high -> back-to-back scans 18 cycles apart (`STEP_CYCLES=1`).
- Fault injection: force `f=0`, `din=16'hFFFF` -> `cap=16'h0000`, `done` pulses.
  - `err=1` with `MUX_SCAN_CHECK_EN`; `err=0` without.
  - `err` clears on the next transfer.
- Reset mid-scan at `s=7` -> all outputs at reset values at once.
  - A `start` on the next edge begins a fresh scan with `s=0` and `cap=0`.
